// File: rtl/v_mem_arbiter.sv
// Two-port VRAM arbiter: round-robin grant, registered issue, read-owner return pipe.
// Define V_MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention).
module v_mem_arbiter #(
  parameter int VRAM_DW = 512,
  parameter int VRAM_AW = 64,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_i,
  input  logic               we0_i,
  input  logic [VRAM_AW-1:0] addr0_i,
  input  logic [VRAM_DW-1:0] mask0_i,
  input  logic [VRAM_DW-1:0] wdata0_i,
  output logic               gnt0_o,
  output logic               rvalid0_o,
  output logic [VRAM_DW-1:0] rdata0_o,
  input  logic               req1_i,
  input  logic               we1_i,
  input  logic [VRAM_AW-1:0] addr1_i,
  input  logic [VRAM_DW-1:0] mask1_i,
  input  logic [VRAM_DW-1:0] wdata1_i,
  output logic               gnt1_o,
  output logic               rvalid1_o,
  output logic [VRAM_DW-1:0] rdata1_o,
  output logic               vram_ren_o,
  output logic               vram_wen_o,
  output logic [VRAM_AW-1:0] vram_addr_o,
  output logic [VRAM_DW-1:0] vram_mask_o,
  output logic [VRAM_DW-1:0] vram_din_o,
  input  logic [VRAM_DW-1:0] vram_dout_i
);

  logic               gnt0, gnt1, any_gnt, we_sel;
  logic               ren_q, ren_d, wen_q, wen_d, owner_q, owner_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [VRAM_DW-1:0] mask_q, mask_d, din_q, din_d;
  logic [RD_LAT-1:0]  rv_q, rv_d, ro_q, ro_d;

`ifdef V_MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = req0_i;
      gnt1 = req1_i & ~req0_i;
    end
  end
`else
  logic last_grant_q, last_grant_d;

  // Under contention the port that did not win last time gets the slot.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_i && req1_i) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0_i;
        gnt1 = req1_i;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0) last_grant_d = 1'b0;
    else if (gnt1) last_grant_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`endif

  assign gnt0_o  = gnt0;
  assign gnt1_o  = gnt1;
  assign any_gnt = gnt0 | gnt1;
  assign we_sel  = gnt1 ? we1_i : we0_i;

  always_comb begin
    ren_d   = any_gnt & ~we_sel;
    wen_d   = any_gnt & we_sel;
    owner_d = gnt1;
    addr_d  = addr_q;
    mask_d  = mask_q;
    din_d   = din_q;
    if (any_gnt) begin
      addr_d = gnt1 ? addr1_i  : addr0_i;
      mask_d = gnt1 ? mask1_i  : mask0_i;
      din_d  = gnt1 ? wdata1_i : wdata0_i;
    end
  end

  // Owner tag rides beside the read strobe so data lands RD_LAT cycles after vram_ren_o.
  always_comb begin
    rv_d    = '0;
    ro_d    = '0;
    rv_d[0] = ren_q;
    ro_d[0] = owner_q;
    for (int i = 1; i < RD_LAT; i++) begin
      rv_d[i] = rv_q[i-1];
      ro_d[i] = ro_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      din_q   <= '0;
      rv_q    <= '0;
      ro_q    <= '0;
    end else begin
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      din_q   <= din_d;
      rv_q    <= rv_d;
      ro_q    <= ro_d;
    end
  end

  assign vram_ren_o  = ren_q;
  assign vram_wen_o  = wen_q;
  assign vram_addr_o = addr_q;
  assign vram_mask_o = mask_q;
  assign vram_din_o  = din_q;

  assign rvalid0_o = rv_q[RD_LAT-1] & ~ro_q[RD_LAT-1];
  assign rvalid1_o = rv_q[RD_LAT-1] &  ro_q[RD_LAT-1];
  assign rdata0_o  = rvalid0_o ? vram_dout_i : '0;
  assign rdata1_o  = rvalid1_o ? vram_dout_i : '0;

endmodule

// File: tb/tb_v_mem_arbiter.sv
// Bench for v_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_v_mem_arbiter;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_i = 0, we0_i = 0, req1_i = 0, we1_i = 0;
  logic [AW-1:0] addr0_i = '0, addr1_i = '0;
  logic [DW-1:0] mask0_i = '0, wdata0_i = '0, mask1_i = '0, wdata1_i = '0;
  logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [DW-1:0] rdata0_o, rdata1_o;
  logic          vram_ren_o, vram_wen_o;
  logic [AW-1:0] vram_addr_o;
  logic [DW-1:0] vram_mask_o, vram_din_o, vram_dout_i;

  v_mem_arbiter #(.VRAM_DW(DW), .VRAM_AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .mask0_i(mask0_i), .wdata0_i(wdata0_i),
    .gnt0_o(gnt0_o), .rvalid0_o(rvalid0_o), .rdata0_o(rdata0_o),
    .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .mask1_i(mask1_i), .wdata1_i(wdata1_i),
    .gnt1_o(gnt1_o), .rvalid1_o(rvalid1_o), .rdata1_o(rdata1_o),
    .vram_ren_o(vram_ren_o), .vram_wen_o(vram_wen_o), .vram_addr_o(vram_addr_o),
    .vram_mask_o(vram_mask_o), .vram_din_o(vram_din_o), .vram_dout_i(vram_dout_i)
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[9:6]);
  endfunction

  function automatic logic [DW-1:0] init_word(input int i);
    logic [DW-1:0] w;
    for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = 32'hC0DE0000 ^ (32'(i) * 32'h00010001) ^ 32'(k);
    return w;
  endfunction

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] w;
    for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Environment RAM: write-first storage, read data delivered RD_LAT cycles after the strobe.
  logic [DW-1:0] ram [16];
  logic [DW-1:0] dly [RD_LAT];
  bit            ram_ready = 1'b0;
  assign vram_dout_i = dly[RD_LAT-1];

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 16; i++) ram[i] = init_word(i);
      ram_ready = 1'b1;
    end
    if (vram_wen_o)
      ram[idx(vram_addr_o)] = (ram[idx(vram_addr_o)] & ~vram_mask_o) | (vram_din_o & vram_mask_o);
    dly[0] <= vram_ren_o ? ram[idx(vram_addr_o)] : rand_wide();
    for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
  end

  typedef struct {
    bit            vld;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] mask;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    int            due;
    bit            port;
    logic [DW-1:0] data;
  } ret_t;

  req_t          pend [2];
  ret_t          ret_q [$];
  logic [DW-1:0] shadow [16];
  int            exp_last;
  bit            exp_ren, exp_wen;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_mask, exp_din;
  int            cyc = 0;
  int            nchk = 0, npass = 0, nfail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] mask, input logic [DW-1:0] data);
    req_t r;
    r.vld = 1'b1; r.we = we; r.addr = addr; r.mask = mask; r.data = data;
    return r;
  endfunction

  function automatic req_t rand_req();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15)) << 6;
    return mk(1'($urandom_range(0, 1)), a,
              ($urandom_range(0, 1) != 0) ? {DW{1'b1}} : rand_wide(), rand_wide());
  endfunction

  task automatic drive();
    req0_i = pend[0].vld; we0_i = pend[0].we; addr0_i = pend[0].addr;
    mask0_i = pend[0].mask; wdata0_i = pend[0].data;
    req1_i = pend[1].vld; we1_i = pend[1].we; addr1_i = pend[1].addr;
    mask1_i = pend[1].mask; wdata1_i = pend[1].data;
  endtask

  task automatic model_reset();
    ret_q.delete();
    exp_last = 1; exp_ren = 0; exp_wen = 0;
    exp_addr = '0; exp_mask = '0; exp_din = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt0"}, gnt0_o, 0);
    chk({tag, "_gnt1"}, gnt1_o, 0);
    chk({tag, "_ren"}, vram_ren_o, 0);
    chk({tag, "_wen"}, vram_wen_o, 0);
    chk({tag, "_addr"}, vram_addr_o, 0);
    chk({tag, "_mask"}, vram_mask_o, 0);
    chk({tag, "_din"}, vram_din_o, 0);
    chk({tag, "_rv0"}, rvalid0_o, 0);
    chk({tag, "_rv1"}, rvalid1_o, 0);
    chk({tag, "_rd0"}, rdata0_o, 0);
    chk({tag, "_rd1"}, rdata1_o, 0);
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic apply_reset();
    pend[0].vld = 0; pend[1].vld = 0;
    drive();
    rst = 1'b1;
    #1;
    model_reset();
    check_all_zero("rst_async");
    repeat (2) begin
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    rst = 1'b0;
    @(posedge clk); cyc++;
    #1;
  endtask

  task automatic tick(input bit spawn);
    bit g0, g1, p, rv0, rv1;
    logic [DW-1:0] rd;
    if (spawn)
      for (int q = 0; q < 2; q++)
        if (!pend[q].vld && $urandom_range(0, 3) != 0) pend[q] = rand_req();
    drive();
    @(negedge clk);
`ifdef V_MEM_ARB_FIXED_PRIO_EN
    g0 = pend[0].vld;
    g1 = pend[1].vld && !pend[0].vld;
`else
    if (pend[0].vld && pend[1].vld) begin
      g0 = (exp_last == 1);
      g1 = !g0;
    end else begin
      g0 = pend[0].vld;
      g1 = pend[1].vld;
    end
`endif
    chk("gnt0", gnt0_o, g0);
    chk("gnt1", gnt1_o, g1);
    chk("gnt_onehot", gnt0_o & gnt1_o, 0);
    chk("ren", vram_ren_o, exp_ren);
    chk("wen", vram_wen_o, exp_wen);
    chk("addr", vram_addr_o, exp_addr);
    chk("mask", vram_mask_o, exp_mask);
    chk("din", vram_din_o, exp_din);
    rv0 = 0; rv1 = 0; rd = '0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      rv0 = !ret_q[0].port;
      rv1 = ret_q[0].port;
      rd  = ret_q[0].data;
      void'(ret_q.pop_front());
    end
    chk("rvalid0", rvalid0_o, rv0);
    chk("rvalid1", rvalid1_o, rv1);
    chk("rdata0", rdata0_o, rv0 ? rd : '0);
    chk("rdata1", rdata1_o, rv1 ? rd : '0);
    @(posedge clk); cyc++;
    exp_ren = 0; exp_wen = 0;
    if (g0 || g1) begin
      p = g1;
      exp_last = int'(p);
      exp_addr = pend[p].addr;
      exp_mask = pend[p].mask;
      exp_din  = pend[p].data;
      if (pend[p].we) begin
        exp_wen = 1;
        shadow[idx(pend[p].addr)] = (shadow[idx(pend[p].addr)] & ~pend[p].mask)
                                  | (pend[p].data & pend[p].mask);
      end else begin
        exp_ren = 1;
        ret_q.push_back('{due: cyc + RD_LAT, port: p, data: shadow[idx(pend[p].addr)]});
      end
      pend[p].vld = 0;
    end
    #1;
  endtask

  task automatic contend(input int n);
    for (int i = 0; i < n; i++) begin
      for (int q = 0; q < 2; q++) if (!pend[q].vld) pend[q] = rand_req();
      tick(0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a5;
    a5 = {(DW/8){8'hA5}};
    for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
    pend[0].vld = 0; pend[1].vld = 0;
    model_reset();
    @(posedge clk); cyc++;
    #1;
    apply_reset();

    // Single port-0 read
    pend[0] = mk(0, 64'h40, {DW{1'b1}}, '0);
    repeat (RD_LAT + 3) tick(0);

    // Contention from reset
    apply_reset();
    contend(4);
    repeat (RD_LAT + 4) tick(0);

    // Port-1 write then read-back of the same address
    pend[1] = mk(1, 64'h80, {DW{1'b1}}, a5);
    tick(0);
    pend[1] = mk(0, 64'h80, {DW{1'b1}}, '0);
    repeat (RD_LAT + 3) tick(0);

    // Interleaved reads across both ports
    pend[0] = mk(0, 64'h00, '0, '0);
    tick(0);
    pend[1] = mk(0, 64'h40, '0, '0);
    tick(0);
    pend[0] = mk(0, 64'h80, '0, '0);
    repeat (RD_LAT + 4) tick(0);

    // Reset while a read is in flight, then contention
    pend[0] = mk(0, 64'hC0, '0, '0);
    tick(0);
    apply_reset();
    contend(1);
    repeat (RD_LAT + 4) tick(0);

    // Three cycles of contention
    contend(3);
    repeat (RD_LAT + 4) tick(0);

    // Random traffic
    repeat (400) tick(1);
    repeat (RD_LAT + 8) tick(0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
